// File: rtl/debug_frame_receiver_if.sv
// FIFO-style UART wrapper link: TX push and show-ahead RX pop between receiver and UART.
interface debug_frame_receiver_if;
    logic       uartDataAvailable;
    logic [7:0] uartReceivedData;
    logic       uartReadFlag;
    logic       uartWriteFlag;
    logic [7:0] uartDataToSend;

    modport master (
        input  uartDataAvailable,
        input  uartReceivedData,
        output uartReadFlag,
        output uartWriteFlag,
        output uartDataToSend
    );

    modport slave (
        output uartDataAvailable,
        output uartReceivedData,
        input  uartReadFlag,
        input  uartWriteFlag,
        input  uartDataToSend
    );
endinterface

// File: rtl/debug_frame_receiver.sv
// Host side of the debug UART link: sends a step/continue command, then
// reassembles the returned big-endian byte dump into a 32-bit capture buffer.
module debug_frame_receiver #(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned FRAME_WORDS    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  CMD_STEP       = 8'h73,
    parameter logic [7:0]  CMD_CONT       = 8'h63
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    startStep,
    input  logic                    startCont,
    debug_frame_receiver_if.master  uart,
    input  logic [ADDR_W-1:0]       captureAddr,
    output logic [31:0]             captureData,
    output logic                    busy,
    output logic                    frameDone,
    output logic                    timeoutErr,
    output logic [ADDR_W:0]         wordCount
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned WC_W   = ADDR_W + 1;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_CMD = 2'd1,
        RECV     = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_timeout_err;
    logic [WC_W-1:0]     r_word_count;
    logic [1:0]          r_idx;
    logic [23:0]         r_shreg;
    logic [TCNT_W-1:0]   r_tcnt;
    logic                r_wr_flag;
    logic [7:0]          r_tx_data;
    logic [31:0]         r_buf [DEPTH];

    state_t              w_state_nxt;
    logic                w_busy_nxt;
    logic                w_frame_done_nxt;
    logic                w_timeout_err_nxt;
    logic [WC_W-1:0]     w_word_count_nxt;
    logic [WC_W-1:0]     w_word_count_inc;
    logic [1:0]          w_idx_nxt;
    logic [23:0]         w_shreg_nxt;
    logic [TCNT_W-1:0]   w_tcnt_nxt;
    logic                w_wr_flag_nxt;
    logic [7:0]          w_tx_data_nxt;
    logic                w_accept;
    logic                w_buf_we;
    logic [31:0]         w_word;

    // Next-state and registered-output computation
    always_comb begin
        w_state_nxt       = r_state;
        w_busy_nxt        = r_busy;
        w_frame_done_nxt  = 1'b0;
        w_timeout_err_nxt = r_timeout_err;
        w_word_count_nxt  = r_word_count;
        w_word_count_inc  = r_word_count + WC_W'(1);
        w_idx_nxt         = r_idx;
        w_shreg_nxt       = r_shreg;
        w_tcnt_nxt        = r_tcnt;
        w_wr_flag_nxt     = 1'b0;
        w_tx_data_nxt     = r_tx_data;
        w_accept          = 1'b0;
        w_buf_we          = 1'b0;
        w_word            = {r_shreg, uart.uartReceivedData};

        case (r_state)
            IDLE: begin
                if (startStep || startCont) begin
                    w_tx_data_nxt     = startStep ? CMD_STEP : CMD_CONT;
                    w_wr_flag_nxt     = 1'b1;
                    w_timeout_err_nxt = 1'b0;
                    w_word_count_nxt  = '0;
                    w_idx_nxt         = '0;
                    w_tcnt_nxt        = '0;
                    w_busy_nxt        = 1'b1;
                    w_state_nxt       = SEND_CMD;
                end
            end
            SEND_CMD: begin
                w_state_nxt = RECV;
            end
            RECV: begin
                if (uart.uartDataAvailable && !reset) begin
                    w_accept    = 1'b1;
                    w_shreg_nxt = {r_shreg[15:0], uart.uartReceivedData};
                    w_idx_nxt   = r_idx + 2'd1;
                    w_tcnt_nxt  = '0;
                    if (r_idx == 2'd3) begin
                        w_buf_we         = 1'b1;
                        w_word_count_nxt = w_word_count_inc;
                        if (w_word_count_inc == WC_W'(FRAME_WORDS)) begin
                            w_frame_done_nxt = 1'b1;
                            w_busy_nxt       = 1'b0;
                            w_state_nxt      = DONE;
                        end
                    end
                end else if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 2)) begin
                    // This idle cycle brings the count to its terminal value
                    w_tcnt_nxt        = TCNT_W'(TIMEOUT_CYCLES - 1);
                    w_timeout_err_nxt = 1'b1;
                    w_busy_nxt        = 1'b0;
                    w_state_nxt       = IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_word_count  <= '0;
            r_idx         <= '0;
            r_shreg       <= '0;
            r_tcnt        <= '0;
            r_wr_flag     <= 1'b0;
            r_tx_data     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_busy        <= w_busy_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_word_count  <= w_word_count_nxt;
            r_idx         <= w_idx_nxt;
            r_shreg       <= w_shreg_nxt;
            r_tcnt        <= w_tcnt_nxt;
            r_wr_flag     <= w_wr_flag_nxt;
            r_tx_data     <= w_tx_data_nxt;
        end
    end

    // Capture buffer survives reset; only completed words are written
    always_ff @(posedge clock) begin
        if (w_buf_we) begin
            r_buf[r_word_count[ADDR_W-1:0]] <= w_word;
        end
    end

    assign uart.uartReadFlag   = w_accept;
    assign uart.uartWriteFlag  = r_wr_flag;
    assign uart.uartDataToSend = r_tx_data;
    assign captureData         = r_buf[captureAddr];
    assign busy                = r_busy;
    assign frameDone           = r_frame_done;
    assign timeoutErr          = r_timeout_err;
    assign wordCount           = r_word_count;

endmodule

// File: doc/debug_frame_receiver.md
Name: debug_frame_receiver

Overview:
- Host-side counterpart of the pipeline debug unit's UART link: issues a single-byte debug command (step or continue) toward the debug unit, then receives the byte stream dump of pipeline/register state it sends back.
- Reassembles the bytes into 32-bit words and stores them in a capture buffer with a random-access read port.
- Used in hardware-in-the-loop benches and in the loopback test FPGA build. Talks to the same FIFO-style UART wrapper interface used by the debug unit.

Parameters:
- ADDR_W, 4: capture buffer address width.
- FRAME_WORDS, 16: 32-bit words per dump frame; must satisfy 1 <= FRAME_WORDS <= 2**ADDR_W.
- TIMEOUT_CYCLES, 1000000: idle cycles allowed between received bytes before the frame is aborted; must be >= 2.
- CMD_STEP, 8'h73: command byte for step ('s').
- CMD_CONT, 8'h63: command byte for continue ('c').

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- startStep  in  1  one-cycle request to send CMD_STEP and capture a frame.
- startCont  in  1  one-cycle request to send CMD_CONT and capture a frame.
- uartDataAvailable  in  1  RX FIFO non-empty.
- uartReceivedData  in  8  RX FIFO head byte; valid whenever uartDataAvailable=1 (show-ahead).
- uartReadFlag  out  1  pops the RX FIFO head at this clock edge.
- uartWriteFlag  out  1  pushes uartDataToSend into the TX FIFO at this clock edge.
- uartDataToSend  out  8  TX byte.
- captureAddr  in  ADDR_W  capture buffer read address.
- captureData  out  32  buffer[captureAddr], combinational read.
- busy  out  1  high from command launch until frame end or abort.
- frameDone  out  1  one-cycle pulse when a full frame has been stored.
- timeoutErr  out  1  sticky abort flag; cleared on the next accepted start.
- wordCount  out  ADDR_W+1  number of complete words stored in the current or last frame.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - uartReadFlag, uartWriteFlag, busy, frameDone and timeoutErr are all 0.
  - uartDataToSend = 0 and wordCount = 0.
  - Byte index, shift register and timeout counter are cleared.
  - Buffer contents are not cleared.
  - Reset mid-frame aborts the frame without raising timeoutErr.
- States are IDLE, SEND_CMD, RECV and DONE.
- IDLE:
  - If startStep or startCont is high, latch the command byte. startStep wins if both are high.
  - Clear timeoutErr, wordCount, the byte index and the timeout counter.
  - Set busy=1 and go to SEND_CMD.
  - Start pulses arriving in any other state are ignored.
- SEND_CMD:
  - Drive uartWriteFlag=1 and uartDataToSend=cmd for exactly one cycle, then go to RECV.
  - uartDataToSend holds its value afterwards.
- RECV, byte accepted:
  - When uartDataAvailable=1, drive uartReadFlag=1 in the same cycle (combinational from state and uartDataAvailable).
  - Shift the byte in: shreg <= {shreg[23:0], byte}. The first byte received becomes bits [31:24] (big-endian).
  - Increment the byte index and reset the timeout counter.
- RECV, back-to-back bytes:
  - uartReadFlag may stay high on consecutive cycles, giving one byte per cycle at maximum throughput.
- RECV, word completion:
  - When the 4th byte of a word is accepted, write buffer[wordCount] <= {shreg[23:0], byte} and increment wordCount.
  - The written value is visible on captureData the next cycle.
  - If the new wordCount equals FRAME_WORDS, go to DONE.
- RECV, timeout:
  - When uartDataAvailable=0, the timeout counter increments.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, set timeoutErr=1, busy=0 and go to IDLE.
  - A partial word is discarded; wordCount keeps the number of complete words stored.
  - A byte arriving in the same cycle as the terminal count is accepted and the timeout is not taken.
- DONE:
  - frameDone=1 for one cycle and busy=0 in that same cycle, then go to IDLE.
  - No further RX bytes are popped once the frame is complete.
  - Excess bytes stay in the RX FIFO; they are consumed as the start of the next frame, which is accepted behaviour.
- Latency: the command push occurs 1 cycle after the start pulse.
- Counter widths:
  - Byte index is 2 bits and wraps 3 -> 0.
  - wordCount never exceeds FRAME_WORDS.
  - The timeout counter is sized for TIMEOUT_CYCLES and saturates at abort.

Test Plan:
1. Reset held 3 cycles, then released -> all outputs 0, state IDLE; uartReadFlag stays 0 even with uartDataAvailable=1.
2. startStep pulse -> next cycle uartWriteFlag=1 with uartDataToSend=8'h73 for exactly 1 cycle.
   - Feed 64 bytes 0x00..0x3F back-to-back -> captureData at addr 0 = 32'h00010203 and at addr 15 = 32'h3C3D3E3F.
   - frameDone pulses once, wordCount=16, busy falls with frameDone.
3. startStep and startCont asserted in the same cycle -> 8'h73 sent.
   - A startCont pulse during RECV is ignored: no second uartWriteFlag.
4. startCont, then bytes fed with random 0-5 cycle gaps (TIMEOUT_CYCLES=8) -> 8'h63 sent, full frame captured correctly, timeoutErr=0.
5. TIMEOUT_CYCLES=8, send 6 bytes then stop -> timeoutErr=1 after 7 idle cycles, wordCount=1, buffer[0] holds the first 4 bytes, busy=0, no frameDone.
   - A following startStep clears timeoutErr.
6. Assert reset after 10 bytes of a frame -> busy=0, wordCount=0, no frameDone or timeoutErr.
   - A new startCont then captures a complete frame normally.
